// File: rtl/au_acc_csv_pkg.sv
// -----------------------------------------------------------------------------
// au_acc_csv_pkg
// Shared definitions for the carry-save streaming accumulator:
//   - state_t / ST_ACC, ST_RES, ST_OUT : 2-bit FSM state encoding
//   - clog2()                          : constant ceil(log2) helper used to size
//                                        the result width and operand counter
// -----------------------------------------------------------------------------
package au_acc_csv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACC = 2'd0;  // accepting operands
  localparam state_t ST_RES = 2'd1;  // resolving ss + cc
  localparam state_t ST_OUT = 2'd2;  // presenting the result

  // ceil(log2(value)); clog2(1) = 0. Evaluated at elaboration only.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/au_acc_csv_csa_row.sv
// -----------------------------------------------------------------------------
// au_acc_csv_csa_row
// Purely combinational row of W full adders used as a 3:2 compressor.
// Ports:
//   x_i, y_i, z_i [W-1:0] : three operands
//   sum_o   [W-1:0]       : bitwise sum (x ^ y ^ z)
//   carry_o [W-1:0]       : bitwise majority, NOT shifted; the caller aligns it
// -----------------------------------------------------------------------------
module au_acc_csv_csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum_o[gi]   = x_i[gi] ^ y_i[gi] ^ z_i[gi];
    assign carry_o[gi] = (x_i[gi] & y_i[gi]) | (x_i[gi] & z_i[gi]) | (y_i[gi] & z_i[gi]);
  end

endmodule

// File: rtl/au_acc_csv.sv
// -----------------------------------------------------------------------------
// au_acc_csv
// Streaming multi-operand accumulator. Operands arrive on a valid/ready
// handshake and are folded into a redundant sum/carry pair (no carry ripple per
// beat). A group closes on in_last or when NMAX operands have been taken; one
// carry-propagate add then resolves the total, which is offered on an output
// handshake.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_vld, in_rdy      : operand handshake
//   in_last             : final operand of the group
//   a       [WIDTH-1:0] : operand, unsigned
//   out_vld, out_rdy    : result handshake
//   s       [OW-1:0]    : group sum, unsigned
//   ovf                 : group was closed by the NMAX count limit
// -----------------------------------------------------------------------------
module au_acc_csv
  import au_acc_csv_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NMAX  = 16,
  localparam int OW    = WIDTH + clog2(NMAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OW-1:0]    s,
  output logic             ovf
);

  localparam int CW = clog2(NMAX + 1);

  if (WIDTH < 1 || NMAX < 2) begin : g_bad_params
    $fatal(1, "au_acc_csv: illegal parameters WIDTH=%0d NMAX=%0d", WIDTH, NMAX);
  end

  state_t          state_q, state_d;
  logic [OW-1:0]   ss_q, ss_d;
  logic [OW-1:0]   cc_q, cc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   s_q, s_d;
  logic            ovf_q, ovf_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_vld_q, out_vld_d;

  logic [OW-1:0]   csa_sum;
  logic [OW-1:0]   csa_carry;
  logic [OW-1:0]   a_ext;
  logic            beat;
  logic            at_limit;
  logic            closing;
  logic            unused_carry_msb;

  assign a_ext    = {{(OW - WIDTH){1'b0}}, a};
  // in_rdy_q is high exactly in ACC, so it doubles as the state qualifier.
  assign beat     = in_vld && in_rdy_q;
  // This beat will be the NMAX-th operand of the group.
  assign at_limit = (cnt_q == CW'(NMAX - 1));
  assign closing  = in_last || at_limit;

  au_acc_csv_csa_row #(
    .W(OW)
  ) u_csa_row (
    .x_i    (ss_q),
    .y_i    (cc_q),
    .z_i    (a_ext),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  // The carry MSB would shift out of range; OW is sized so it is always zero.
  assign unused_carry_msb = csa_carry[OW-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (beat && closing) state_d = ST_RES;
      ST_RES:  state_d = ST_OUT;
      ST_OUT:  if (out_rdy) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Decoded from the next state and registered, so the handshake
  // flags track the state register with no combinational input path.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_rdy_d  = (state_d == ST_ACC);
    out_vld_d = (state_d == ST_OUT);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ss_d  = ss_q;
    cc_d  = cc_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          ss_d  = csa_sum;
          cc_d  = {csa_carry[OW-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (closing) begin
            ovf_d = at_limit && !in_last;
          end
        end
      end
      ST_RES: begin
        s_d   = ss_q + cc_q;
        ss_d  = '0;
        cc_d  = '0;
        cnt_d = '0;
      end
      ST_OUT: begin
        if (out_rdy) begin
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q      <= '0;
      cc_q      <= '0;
      cnt_q     <= '0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      ss_q      <= ss_d;
      cc_q      <= cc_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      ovf_q     <= ovf_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;
  assign s       = s_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_au_acc_csv.sv
// -----------------------------------------------------------------------------
// tb_au_acc_csv
// Scoreboard bench: the driver keeps a running per-group total and pushes the
// expected {sum, ovf, closing cycle} whenever a group closes; an independent
// monitor drives out_rdy and checks each presented result against the queue.
// -----------------------------------------------------------------------------
module tb_au_acc_csv;

  localparam int WIDTH = 8;
  localparam int NMAX  = 4;
  localparam int OW    = 10;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             in_vld  = 1'b0;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] a       = '0;
  logic             out_rdy = 1'b0;
  logic             in_rdy;
  logic             out_vld;
  logic [OW-1:0]    s;
  logic             ovf;

  au_acc_csv #(
    .WIDTH(WIDTH),
    .NMAX (NMAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .in_last(in_last),
    .a      (a),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .s      (s),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the cycle in
  // progress.
  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int sum;
    bit ovf;
    int close_cycle;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: the group being built.
  int grp_sum = 0;
  int grp_cnt = 0;
  bit force_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Present one operand from a falling edge until it is taken.
  task automatic send(input logic [WIDTH-1:0] val, input bit last);
    int waited;
    waited = 0;
    @(negedge clk);
    in_vld  = 1'b1;
    a       = val;
    in_last = last;
    while (!in_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_rdy stayed 0 for %0d cycles, expected 1", waited);
      in_vld = 1'b0;
      return;
    end
    // Taken at the coming rising edge, during the current cycle.
    $display("beat: a=%0d last=%0d cycle=%0d", val, last, cycle);
    grp_sum += int'(val);
    grp_cnt++;
    if (last || grp_cnt == NMAX) begin
      exp_q.push_back('{grp_sum, (grp_cnt == NMAX) && !last, cycle});
      grp_sum = 0;
      grp_cnt = 0;
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || out_vld) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || out_vld) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d out_vld=%0d, expected 0 and 0", exp_q.size(), out_vld);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: owns out_rdy, compares every presented result.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit   prev_vld;
    bit   chk_after;
    int   stall;
    exp_t e;
    prev_vld  = 1'b0;
    chk_after = 1'b0;
    stall     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld  = 1'b0;
        chk_after = 1'b0;
        out_rdy   = 1'b0;
        continue;
      end
      if (chk_after) begin
        check("in_rdy_after_out", in_rdy, 1);
        check("out_vld_dropped", out_vld, 0);
        chk_after = 1'b0;
      end
      if (out_vld) begin
        check("in_rdy_low_in_out", in_rdy, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: s=%0d ovf=%0d, expected no output", s, ovf);
          out_rdy = 1'b1;
        end else begin
          e = exp_q[0];
          if (!prev_vld) begin
            stall = force_stall ? 3 : int'($urandom_range(0, 2));
            // Closing beat taken during cycle c: RES after edge c+1, OUT after c+2.
            check("latency", cycle, e.close_cycle + 2);
          end
          check("s", s, e.sum);
          check("ovf", ovf, e.ovf);
          if (stall > 0) begin
            out_rdy = 1'b0;
            stall--;
          end else begin
            out_rdy = 1'b1;
            $display("result: s=%0d ovf=%0d expected s=%0d ovf=%0d", s, ovf, e.sum, e.ovf);
            void'(exp_q.pop_front());
            chk_after = 1'b1;
          end
        end
      end else begin
        out_rdy = 1'($urandom_range(0, 1));
      end
      prev_vld = out_vld;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int len;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s", s, 0);
    check("reset_ovf", ovf, 0);
    check("reset_out_vld", out_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_rdy", in_rdy, 1);

    // Basic group with 3-cycle back-pressure on the result.
    force_stall = 1'b1;
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    drain();
    force_stall = 1'b0;

    // Maximum value, closed by in_last on the NMAX-th beat.
    for (int i = 0; i < NMAX; i++) send(8'd255, i == NMAX - 1);
    drain();

    // Count limit closes the first group; the fifth beat opens the next one.
    for (int i = 0; i < 5; i++) send(8'd255, 1'b0);
    send(8'd1, 1'b1);
    drain();

    // Single-operand group.
    send(8'd200, 1'b1);
    drain();

    // Asynchronous reset mid-group.
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s", s, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_out_vld", out_vld, 0);
    grp_sum = 0;
    grp_cnt = 0;
    #1 rst_n = 1'b1;
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    drain();

    // Random groups; lengths above NMAX exercise the count limit.
    for (int g = 0; g < 40; g++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(WIDTH'($urandom_range(0, 255)), i == len - 1);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
